imem_fetch_tracker: RTL and testbench
=====================================

# imem_fetch_tracker

Parametrised instruction-fetch tracker for formal and simulation benches of MR1-class cores. It sits between the core's instruction request/response ports and the environment's free-running fetch signals. It records the address of every accepted fetch in an in-order queue of up to DEPTH outstanding requests, and splices the checker's monitored parcel (`mon_addr`/`mon_data`) into the matching 16-bit lane of the response returned to the core. The single-outstanding, fixed-32-bit tracking the core benches use today is generalised to multiple in-flight fetches, configurable fetch width and optional fetch flush.

## Interface
- XLEN, 32: address width.
- DATA_W, 32: fetch word width; a multiple of 16. NPARCEL = DATA_W/16.
- DEPTH, 4: maximum number of outstanding fetches; at least 1.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  core fetch request valid.
- req_ready_in  in  1  environment ready for the request.
- req_ready_out  out  1  ready presented to the core.
- req_addr  in  XLEN  fetch address; may be any 2-byte-aligned value.
- rsp_valid_in  in  1  environment response valid.
- rsp_data_in  in  DATA_W  environment response data.
- rsp_valid_out  out  1  response valid presented to the core.
- rsp_data_out  out  DATA_W  response data presented to the core.
- rsp_match  out  1  the current forwarded response had a lane replaced.
- mon_addr  in  XLEN  monitored parcel address from the checker.
- mon_data  in  16  monitored parcel contents.
- flush  in  1  discard all outstanding fetches; present only with IMEM_TRACK_FLUSH_EN.
- outstanding  out  $clog2(DEPTH+1)  number of queued fetches.
- err_orphan  out  1  sticky flag: a response arrived with no outstanding fetch.

## Operation
- **Accept.** A fetch is accepted when req_valid, req_ready_in and !full are all high. req_ready_out = req_ready_in & !full.
- **No accept when full.** A fetch is not accepted while full, even if a pop happens in the same cycle.
- **Queue.** The queue is a circular FIFO of DEPTH entries. Each entry holds the address and, with the macro, a stale bit. Read and write pointers wrap modulo DEPTH.
- **Pop.** A response pops the queue when rsp_valid_in is high and the queue was non-empty at the start of the cycle. There is no bypass: a request pushed in the same cycle is never popped in that cycle.
- **Lane splice.** For each k in 0..NPARCEL-1: if mon_addr == head_addr + 2k (modulo 2^XLEN), lane k of rsp_data_out is mon_data. Otherwise lane k is rsp_data_in[16k+15:16k].
  - At most one lane can match; wrap-around of the address sum is legal.
  - rsp_match is high when any lane matched on a forwarded response.
- **Forward.** rsp_valid_out = rsp_valid_in & non-empty (& !head_stale with the macro).
- **Orphan response.** rsp_valid_in while the queue is empty sets err_orphan. The queue is unchanged and rsp_valid_out stays 0.
- **Outstanding count.** outstanding is incremented on a push, decremented on a pop, and unchanged when both happen in the same cycle.
- **Reset.** Reset low at a clock edge empties the queue, clears all stale bits, clears outstanding to 0 and clears err_orphan to 0. Any fetch in flight is forgotten.
- **Outputs during reset.** While reset is low, req_ready_out and rsp_valid_out are forced to 0, and rsp_match is 0.

## Timing
- The response path is combinational, with zero-cycle latency from rsp_valid_in/rsp_data_in to rsp_valid_out/rsp_data_out.
- req_ready_out is combinational from req_ready_in and the registered full flag.
- outstanding and err_orphan are registered and update one cycle after the triggering event.
- Peak throughput is one push and one pop per cycle.

## Configuration
- **IMEM_TRACK_FLUSH_EN defined:**
  - The flush port exists.
  - flush high at an edge marks every entry present before that cycle as stale. An entry pushed in the same cycle stays live.
  - A response popping a stale head is consumed: the entry is removed and outstanding decrements, but rsp_valid_out=0 and rsp_match=0.
  - Flush together with a pop removes the head normally. The head's stale status is sampled before the flush takes effect.
- **IMEM_TRACK_FLUSH_EN undefined:**
  - No flush port and no stale bits.
  - Every popped response is forwarded.

## Test plan
- **Single fetch, lane 0.** DATA_W=32. Accept addr 0x100; mon_addr=0x100, mon_data=0xABCD; respond with 0x11223344 -> rsp_data_out=0x1122ABCD, rsp_match=1, outstanding 1->0.
- **Upper lane with wrap-around.** Accept addr 0xFFFFFFFE; mon_addr=0x00000000, mon_data=0x5555; respond with 0x11223344 -> rsp_data_out=0x55553344.
- **Full queue.** DEPTH=4. Push 4 fetches without responses -> outstanding=4, req_ready_out=0 with req_ready_in=1. Then four responses -> forwarded in order with the correct per-head splice; outstanding=0.
- **Orphan.** Pulse rsp_valid_in with an empty queue, with a push in the same cycle -> rsp_valid_out=0, err_orphan=1 next cycle and held, outstanding=1.
- **Flush.** Macro defined. Push A and B, assert flush with C pushed in the same cycle; three responses follow -> first two give rsp_valid_out=0, the third is forwarded using C's address.
- **Reset mid-operation.** Three outstanding fetches and err_orphan=1; reset low for one edge -> outstanding=0, err_orphan=0. A subsequent response raises err_orphan.

Source files
------------

// File: rtl/imem_fetch_tracker.sv
// In-order fetch tracker: queues accepted fetch addresses and splices the monitored parcel into responses.
// Optional flush support (stale entries) is enabled with `define IMEM_TRACK_FLUSH_EN.
module imem_fetch_tracker #(
  parameter int XLEN   = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_ready_in,
  output logic              req_ready_out,
  input  logic [XLEN-1:0]   req_addr,
  input  logic              rsp_valid_in,
  input  logic [DATA_W-1:0] rsp_data_in,
  output logic              rsp_valid_out,
  output logic [DATA_W-1:0] rsp_data_out,
  output logic              rsp_match,
  input  logic [XLEN-1:0]   mon_addr,
  input  logic [15:0]       mon_data,
`ifdef IMEM_TRACK_FLUSH_EN
  input  logic              flush,
`endif
  output logic [CW-1:0]     outstanding,
  output logic              err_orphan
);

  localparam int NP = DATA_W / 16;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [XLEN-1:0]   addr_q [DEPTH];
  logic [PW-1:0]     rd_q, rd_d;
  logic [PW-1:0]     wr_q, wr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              full, empty;
  logic              push, pop, fwd, hit;
  logic              head_stale;
  logic [XLEN-1:0]   head_addr;
  logic [DATA_W-1:0] data_d;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (cnt_q == CW'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign head_addr = addr_q[rd_q];

  assign req_ready_out = reset & req_ready_in & ~full;
  assign push          = req_valid & req_ready_out;
  assign pop           = reset & rsp_valid_in & ~empty;

`ifdef IMEM_TRACK_FLUSH_EN
  logic [DEPTH-1:0] stale_q, stale_d;

  assign head_stale = stale_q[rd_q];

  // Flush marks everything; the slot written this cycle is then revived.
  always_comb begin
    stale_d = stale_q;
    if (flush) stale_d = '1;
    if (push) stale_d[wr_q] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) stale_q <= '0;
    else        stale_q <= stale_d;
  end
`else
  assign head_stale = 1'b0;
`endif

  assign fwd           = pop & ~head_stale;
  assign rsp_valid_out = fwd;
  assign rsp_match     = fwd & hit;
  assign rsp_data_out  = data_d;

  always_comb begin
    data_d = rsp_data_in;
    hit    = 1'b0;
    for (int k = 0; k < NP; k++) begin
      if (mon_addr == head_addr + XLEN'(2 * k)) begin
        data_d[16*k +: 16] = mon_data;
        hit                = 1'b1;
      end
    end
  end

  always_comb begin
    rd_d  = pop ? nxt(rd_q) : rd_q;
    wr_d  = push ? nxt(wr_q) : wr_q;
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
    err_d = err_q | (rsp_valid_in & empty);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) addr_q[wr_q] <= req_addr;
  end

  assign outstanding = cnt_q;
  assign err_orphan  = err_q;

endmodule

// File: tb/tb_imem_fetch_tracker.sv
// Randomised scoreboard bench for imem_fetch_tracker against a queue-based reference model.
module tb_imem_fetch_tracker;

  localparam int XLEN   = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int NP     = DATA_W / 16;
  localparam int CW     = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid, req_ready_in, req_ready_out;
  logic [XLEN-1:0]   req_addr;
  logic              rsp_valid_in, rsp_valid_out, rsp_match;
  logic [DATA_W-1:0] rsp_data_in, rsp_data_out;
  logic [XLEN-1:0]   mon_addr;
  logic [15:0]       mon_data;
  logic              flush;
  logic [CW-1:0]     outstanding;
  logic              err_orphan;

  always #5 clk = ~clk;

  imem_fetch_tracker #(.XLEN(XLEN), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready_in(req_ready_in),
    .req_ready_out(req_ready_out),
    .req_addr(req_addr),
    .rsp_valid_in(rsp_valid_in),
    .rsp_data_in(rsp_data_in),
    .rsp_valid_out(rsp_valid_out),
    .rsp_data_out(rsp_data_out),
    .rsp_match(rsp_match),
    .mon_addr(mon_addr),
    .mon_data(mon_data),
`ifdef IMEM_TRACK_FLUSH_EN
    .flush(flush),
`endif
    .outstanding(outstanding),
    .err_orphan(err_orphan)
  );

  typedef struct {
    logic [XLEN-1:0] addr;
    bit              stale;
  } ent_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    bit                match;
  } rsp_t;

  ent_t mq[$];
  rsp_t sb[$];
  bit   merr;
  int   exp_out;
  bit   exp_err;
  bit   exp_rdy;
  bit   run = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference splice: byte distance from the head picks the lane.
  function automatic rsp_t model_rsp(input logic [XLEN-1:0] head,
                                     input logic [DATA_W-1:0] d,
                                     input logic [XLEN-1:0] ma,
                                     input logic [15:0] md);
    rsp_t r;
    logic [XLEN-1:0] off;
    off     = ma - head;
    r.data  = d;
    r.match = 1'b0;
    if (off[0] == 1'b0 && off < XLEN'(DATA_W / 8)) begin
      r.data[off*8 +: 16] = md;
      r.match             = 1'b1;
    end
    return r;
  endfunction

  task automatic step(input bit rst, input bit rv, input bit rri,
                      input logic [XLEN-1:0] a, input bit rsv,
                      input logic [DATA_W-1:0] d, input logic [XLEN-1:0] ma,
                      input logic [15:0] md, input bit fl);
    bit psh, pp;
    reset        = rst;
    req_valid    = rv;
    req_ready_in = rri;
    req_addr     = a;
    rsp_valid_in = rsv;
    rsp_data_in  = d;
    mon_addr     = ma;
    mon_data     = md;
    flush        = fl;
    psh     = rst && rv && rri && (mq.size() < DEPTH);
    pp      = rst && rsv && (mq.size() > 0);
    exp_out = mq.size();
    exp_err = merr;
    exp_rdy = rst && rri && (mq.size() < DEPTH);
    if (pp && !mq[0].stale) sb.push_back(model_rsp(mq[0].addr, d, ma, md));
    @(posedge clk);
    if (!rst) begin
      mq.delete();
      merr = 1'b0;
    end else begin
      if (rsv && mq.size() == 0) merr = 1'b1;
      if (pp) void'(mq.pop_front());
      if (flush) foreach (mq[i]) mq[i].stale = 1'b1;
      if (psh) mq.push_back('{addr: a, stale: 1'b0});
    end
    #1;
  endtask

  task automatic idle();
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("outstanding", 64'(outstanding), 64'(exp_out));
      chk("err_orphan", 64'(err_orphan), 64'(exp_err));
      chk("req_ready_out", 64'(req_ready_out), 64'(exp_rdy));
      if (rsp_valid_out === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 64'(rsp_valid_out), 64'(0));
        end else begin
          rsp_t e;
          e = sb.pop_front();
          chk("rsp_data_out", 64'(rsp_data_out), 64'(e.data));
          chk("rsp_match", 64'(rsp_match), 64'(e.match));
        end
      end else begin
        chk("rsp_match_idle", 64'(rsp_match), 64'(0));
        if (sb.size() != 0) begin
          chk("rsp_valid_out", 64'(rsp_valid_out), 64'(1));
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    merr = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    run = 1'b1;
    step(0, 1, 1, 32'h40, 1, 0, 0, 0, 0);
    idle();

    // Single fetch, lane 0
    step(1, 1, 1, 32'h100, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 1, 32'h11223344, 32'h100, 16'hABCD, 0);
    idle();

    // Upper lane with address wrap
    step(1, 1, 1, 32'hFFFFFFFE, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 1, 32'h11223344, 32'h0, 16'h5555, 0);
    idle();

    // Fill the queue, try one more, then drain in order
    for (int i = 0; i < 5; i++)
      step(1, 1, 1, 32'h2000 + 32'(i * 6), 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      step(1, 0, 1, 0, 1, 32'hA0B0C0D0 + 32'(i), 32'h2000 + 32'(i * 6 + 2 * (i % 2)),
           16'h1000 + 16'(i), 0);
    idle();

    // Orphan response with a push in the same cycle
    step(1, 1, 1, 32'h300, 1, 32'hDEADBEEF, 32'h300, 16'h7777, 0);
    idle();
    step(1, 0, 1, 0, 1, 32'hCAFEF00D, 32'h302, 16'h8888, 0);
    idle();

`ifdef IMEM_TRACK_FLUSH_EN
    step(1, 1, 1, 32'h400, 0, 0, 0, 0, 0);
    step(1, 1, 1, 32'h404, 0, 0, 0, 0, 0);
    step(1, 1, 1, 32'h408, 0, 0, 0, 0, 1);
    step(1, 0, 1, 0, 1, 32'h1, 32'h400, 16'h1111, 0);
    step(1, 0, 1, 0, 1, 32'h2, 32'h404, 16'h2222, 0);
    step(1, 0, 1, 0, 1, 32'h33334444, 32'h40A, 16'h3333, 0);
    idle();
`endif

    // Reset mid-operation, then an orphan
    step(1, 0, 1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step(1, 1, 1, 32'h500 + 32'(i * 4), 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0);
    idle();
    step(1, 0, 1, 0, 1, 32'h12345678, 32'h500, 16'h9999, 0);
    idle();

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a, d, ma, r;
      bit rst, rv, rri, rsv, fl;
      rst = ($urandom_range(0, 99) != 0);
      rv  = ($urandom_range(0, 9) < 6);
      rri = ($urandom_range(0, 9) < 8);
      rsv = ($urandom_range(0, 9) < 5);
      a   = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'hFFFFFFF8 | a;
      a[0] = 1'b0;
      d   = $urandom;
      r   = $urandom;
      if (mq.size() > 0 && $urandom_range(0, 9) < 7)
        ma = mq[0].addr + 32'(2 * $urandom_range(0, NP));
      else
        ma = r;
`ifdef IMEM_TRACK_FLUSH_EN
      fl = ($urandom_range(0, 9) == 0);
`else
      fl = 1'b0;
`endif
      step(rst, rv, rri, a, rsv, d, ma, 16'($urandom), fl);
    end

    idle();
    idle();
    run = 1'b0;
    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
